// File: rtl/mem_pkg.sv
// Shared load/store funct3 encodings, FSM state type and access-legality helpers
// for the memory stage.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Stores only have signed-less encodings; doubleword forms need a 64-bit datapath.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store,
                                    input logic wide);
    logic ok_s;
    if (is_store) begin
      case (f3)
        F3_B, F3_H, F3_W: ok_s = 1'b1;
        F3_D:             ok_s = wide;
        default:          ok_s = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: ok_s = 1'b1;
        F3_D, F3_WU:                    ok_s = wide;
        default:                        ok_s = 1'b0;
      endcase
    end
    return ok_s;
  endfunction

  // size_log2 is funct3[1:0]: 0 byte, 1 half, 2 word, 3 double.
  function automatic logic addr_aligned(input logic [1:0] size_log2, input logic [2:0] off);
    logic ok_s;
    case (size_log2)
      2'd0:    ok_s = 1'b1;
      2'd1:    ok_s = (off[0] == 1'b0);
      2'd2:    ok_s = (off[1:0] == 2'b00);
      default: ok_s = (off == 3'b000);
    endcase
    return ok_s;
  endfunction

endpackage

// File: rtl/mem_stage_pipe_dmem_bank.sv
// Data memory: byte-enabled synchronous write, combinational read, no reset.
module dmem_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [DATA_WIDTH/8-1:0]      be,
  input  logic [$clog2(DEPTH)-1:0]     idx,
  input  logic [DATA_WIDTH-1:0]        wdata,
  output logic [DATA_WIDTH-1:0]        rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Commit only the enabled byte lanes of the addressed word
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[idx];

endmodule

// File: rtl/mem_stage_pipe.sv
// Execute-to-memory pipeline register with a wait-state memory access FSM,
// little-endian sub-word loads/stores and alignment/encoding fault detection.
module mem_stage_pipe
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DMEM_SIZE     = 64,
  parameter int WAIT_STATES   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_e,
  input  logic                     reg_write_e,
  input  logic [1:0]               result_src_e,
  input  logic                     mem_read_e,
  input  logic                     mem_write_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  input  logic                     flush_m,
  output logic                     stall_e,
  output logic                     valid_m,
  output logic                     reg_write_m,
  output logic [1:0]               result_src_m,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [DATA_WIDTH-1:0]    read_data_m,
  output logic [4:0]               rd_m,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_m,
  output logic                     fault_m
);

  localparam int         NB       = DATA_WIDTH / 8;
  localparam int         OFF_W    = $clog2(NB);
  localparam int         IDX_W    = $clog2(DMEM_SIZE);
  localparam logic       WIDE     = (DATA_WIDTH == 32'sd64);
  localparam logic       HAS_WAIT = (WAIT_STATES > 32'sd0);
  localparam logic [1:0] WS_M1    = HAS_WAIT ? 2'(WAIT_STATES - 32'sd1) : 2'd0;

  mem_state_e            state_r, state_nxt_s;
  logic [1:0]            cnt_r, cnt_nxt_s;
  logic                  is_mem_s, fault_s, legal_mem_s;
  logic                  stall_s, commit_s, we_s;
  logic [OFF_W-1:0]      off_s;
  logic [IDX_W-1:0]      idx_s;
  logic [NB-1:0]         be_s;
  logic [DATA_WIDTH-1:0] wdata_s, rdata_s, shifted_s, load_s;

  assign off_s       = alu_result_e[OFF_W-1:0];
  assign idx_s       = alu_result_e[OFF_W +: IDX_W];
  assign is_mem_s    = valid_e & (mem_read_e | mem_write_e);
  assign fault_s     = is_mem_s & (~f3_legal(funct3_e, mem_write_e, WIDE)
                                   | ~addr_aligned(funct3_e[1:0], alu_result_e[2:0]));
  assign legal_mem_s = is_mem_s & ~fault_s;
  assign we_s        = commit_s & mem_write_e;
  assign stall_e     = stall_s;

  // Store lane steering: byte enables and data shifted to the byte offset
  always_comb begin
    be_s = {NB{1'b0}};
    case (funct3_e[1:0])
      2'd0:    be_s = NB'(8'h01);
      2'd1:    be_s = NB'(8'h03);
      2'd2:    be_s = NB'(8'h0F);
      default: be_s = NB'(8'hFF);
    endcase
    be_s    = be_s << off_s;
    wdata_s = write_data_e << {off_s, 3'b000};
  end

  // Load extraction with sign/zero extension to the full data width
  always_comb begin
    shifted_s = rdata_s >> {off_s, 3'b000};
    case (funct3_e)
      F3_B:    load_s = DATA_WIDTH'($signed(shifted_s[7:0]));
      F3_H:    load_s = DATA_WIDTH'($signed(shifted_s[15:0]));
      F3_W:    load_s = DATA_WIDTH'($signed(shifted_s[31:0]));
      F3_BU:   load_s = DATA_WIDTH'(shifted_s[7:0]);
      F3_HU:   load_s = DATA_WIDTH'(shifted_s[15:0]);
      F3_WU:   load_s = DATA_WIDTH'(shifted_s[31:0]);
      default: load_s = shifted_s;
    endcase
  end

  // FSM state and wait-counter register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 2'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    if (flush_m) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (legal_mem_s && HAS_WAIT) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = WS_M1;
          end else begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 2'd0;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 2'd0) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 2'd0;
          end else begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = cnt_r - 2'd1;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 2'd0;
        end
      endcase
    end
  end

  // FSM outputs: stall request and access commit; flush beats completion
  always_comb begin
    stall_s  = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        stall_s  = legal_mem_s & HAS_WAIT;
        commit_s = legal_mem_s & ~HAS_WAIT;
      end
      ST_WAIT: begin
        stall_s  = (cnt_r != 2'd0);
        commit_s = legal_mem_s & (cnt_r == 2'd0);
      end
      default: begin
        stall_s  = 1'b0;
        commit_s = 1'b0;
      end
    endcase
    stall_s  = stall_s & rst_n;
    commit_s = commit_s & rst_n & ~flush_m;
  end

  // M-stage pipeline register; bubbles on flush, stall or an invalid slot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      result_src_m <= 2'b00;
      alu_result_m <= {DATA_WIDTH{1'b0}};
      read_data_m  <= {DATA_WIDTH{1'b0}};
      rd_m         <= 5'd0;
      pc_plus4_m   <= {ADDRESS_WIDTH{1'b0}};
      fault_m      <= 1'b0;
    end else if (flush_m || stall_s || !valid_e) begin
      valid_m     <= 1'b0;
      reg_write_m <= 1'b0;
      fault_m     <= 1'b0;
    end else begin
      valid_m      <= 1'b1;
      reg_write_m  <= reg_write_e & ~fault_s;
      result_src_m <= result_src_e;
      alu_result_m <= alu_result_e;
      read_data_m  <= load_s;
      rd_m         <= rd_e;
      pc_plus4_m   <= pc_plus4_e;
      fault_m      <= fault_s;
    end
  end

  dmem_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DMEM_SIZE)
  ) u_dmem (
    .clk  (clk),
    .we   (we_s),
    .be   (be_s),
    .idx  (idx_s),
    .wdata(wdata_s),
    .rdata(rdata_s)
  );

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench: three instances (0, 2 and 3 wait states) sharing the execute
// bus, each selected by its own valid_e, checked against hand-computed values.
module tb_mem_stage_pipe;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_e [3];
  logic        reg_write_e;
  logic [1:0]  result_src_e;
  logic        mem_read_e, mem_write_e;
  logic [2:0]  funct3_e;
  logic [31:0] alu_result_e, write_data_e, pc_plus4_e;
  logic [4:0]  rd_e;
  logic        flush_m;

  logic        stall_e [3], valid_m [3], reg_write_m [3], fault_m [3];
  logic [1:0]  result_src_m [3];
  logic [31:0] alu_result_m [3], read_data_m [3], pc_plus4_m [3];
  logic [4:0]  rd_m [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_pipe #(
      .ADDRESS_WIDTH(32),
      .DATA_WIDTH   (32),
      .DMEM_SIZE    (64),
      .WAIT_STATES  ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .valid_e     (valid_e[g]),
      .reg_write_e (reg_write_e),
      .result_src_e(result_src_e),
      .mem_read_e  (mem_read_e),
      .mem_write_e (mem_write_e),
      .funct3_e    (funct3_e),
      .alu_result_e(alu_result_e),
      .write_data_e(write_data_e),
      .rd_e        (rd_e),
      .pc_plus4_e  (pc_plus4_e),
      .flush_m     (flush_m),
      .stall_e     (stall_e[g]),
      .valid_m     (valid_m[g]),
      .reg_write_m (reg_write_m[g]),
      .result_src_m(result_src_m[g]),
      .alu_result_m(alu_result_m[g]),
      .read_data_m (read_data_m[g]),
      .rd_m        (rd_m[g]),
      .pc_plus4_m  (pc_plus4_m[g]),
      .fault_m     (fault_m[g])
    );
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 2 : 3;
  endfunction

  task automatic drive(input int g, input logic rw, input logic mr, input logic mw,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd);
    for (int i = 0; i < 3; i++) valid_e[i] = (i == g);
    reg_write_e  = rw;
    result_src_e = mr ? 2'b01 : 2'b00;
    mem_read_e   = mr;
    mem_write_e  = mw;
    funct3_e     = f3;
    alu_result_e = a;
    write_data_e = wd;
    rd_e         = rd;
    pc_plus4_e   = a + 32'd4;
  endtask

  task automatic go_idle();
    for (int i = 0; i < 3; i++) valid_e[i] = 1'b0;
    mem_read_e  = 1'b0;
    mem_write_e = 1'b0;
    flush_m     = 1'b0;
  endtask

  // Holds a memory op until it completes; outputs are then ready to check
  task automatic mem_op(input int g, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    drive(g, mr, mr, mw, f3, a, wd, 5'd10);
    repeat (ws_of(g) + 1) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    go_idle();
    reg_write_e = 1'b0; result_src_e = 2'b00; funct3_e = 3'b000;
    alu_result_e = 32'd0; write_data_e = 32'd0; rd_e = 5'd0; pc_plus4_e = 32'd0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check_val("rst_valid", valid_m[g], 1'b0);
      check_val("rst_stall", stall_e[g], 1'b0);
      check_val("rst_rdata", read_data_m[g], 32'd0);
    end
    rst_n = 1'b1;

    // pass-through
    drive(0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h1234, 32'd0, 5'd5);
    #1 check_val("pt_stall", stall_e[0], 1'b0);
    @(negedge clk);
    check_val("pt_valid", valid_m[0], 1'b1);
    check_val("pt_alu", alu_result_m[0], 32'h1234);
    check_val("pt_rd", rd_m[0], 5'd5);
    check_val("pt_regw", reg_write_m[0], 1'b1);
    check_val("pt_pc", pc_plus4_m[0], 32'h1238);
    go_idle();
    @(negedge clk);
    check_val("bubble_valid", valid_m[0], 1'b0);

    // byte access
    mem_op(0, 1'b0, 1'b1, F3_W, 32'h10, 32'h80FF7F01);
    check_val("sw_valid", valid_m[0], 1'b1);
    check_val("sw_regw", reg_write_m[0], 1'b0);
    mem_op(0, 1'b1, 1'b0, F3_B, 32'h11, 32'd0);
    check_val("lb_11", read_data_m[0], 32'h0000007F);
    mem_op(0, 1'b1, 1'b0, F3_B, 32'h13, 32'd0);
    check_val("lb_13", read_data_m[0], 32'hFFFFFF80);
    mem_op(0, 1'b1, 1'b0, F3_BU, 32'h13, 32'd0);
    check_val("lbu_13", read_data_m[0], 32'h00000080);
    mem_op(0, 1'b1, 1'b0, F3_H, 32'h12, 32'd0);
    check_val("lh_12", read_data_m[0], 32'hFFFF80FF);
    mem_op(0, 1'b1, 1'b0, F3_HU, 32'h12, 32'd0);
    check_val("lhu_12", read_data_m[0], 32'h000080FF);

    // misalignment and illegal encoding
    drive(0, 1'b1, 1'b1, 1'b0, F3_W, 32'h22, 32'd0, 5'd7);
    #1 check_val("mis_stall", stall_e[0], 1'b0);
    @(negedge clk);
    check_val("mis_fault", fault_m[0], 1'b1);
    check_val("mis_regw", reg_write_m[0], 1'b0);
    check_val("mis_valid", valid_m[0], 1'b1);
    mem_op(0, 1'b0, 1'b1, F3_W, 32'h20, 32'h11223344);
    mem_op(0, 1'b0, 1'b1, F3_H, 32'h21, 32'h0000BEEF);
    check_val("sh_mis_fault", fault_m[0], 1'b1);
    mem_op(0, 1'b1, 1'b0, F3_W, 32'h20, 32'd0);
    check_val("sh_mis_mem", read_data_m[0], 32'h11223344);
    mem_op(0, 1'b0, 1'b1, F3_B, 32'h21, 32'h000000AA);
    mem_op(0, 1'b1, 1'b0, F3_W, 32'h20, 32'd0);
    check_val("sb_lane", read_data_m[0], 32'h1122AA44);
    mem_op(0, 1'b1, 1'b0, F3_D, 32'h28, 32'd0);
    check_val("ld_illegal", fault_m[0], 1'b1);

    // address wrap, and a write with valid_e=0 must be ignored
    mem_op(0, 1'b0, 1'b1, F3_W, 32'h100, 32'hCAFEF00D);
    mem_op(0, 1'b1, 1'b0, F3_W, 32'h000, 32'd0);
    check_val("wrap", read_data_m[0], 32'hCAFEF00D);
    drive(0, 1'b0, 1'b0, 1'b1, F3_W, 32'h0, 32'h0, 5'd0);
    valid_e[0] = 1'b0;
    @(negedge clk);
    check_val("inv_valid", valid_m[0], 1'b0);
    mem_op(0, 1'b1, 1'b0, F3_W, 32'h000, 32'd0);
    check_val("inv_nowrite", read_data_m[0], 32'hCAFEF00D);

    // two wait states
    mem_op(1, 1'b0, 1'b1, F3_W, 32'h30, 32'h0BADF00D);
    check_val("ws2_sw_valid", valid_m[1], 1'b1);
    drive(1, 1'b1, 1'b1, 1'b0, F3_W, 32'h30, 32'd0, 5'd3);
    #1 check_val("ws2_stall0", stall_e[1], 1'b1);
    @(negedge clk);
    check_val("ws2_valid1", valid_m[1], 1'b0);
    check_val("ws2_stall1", stall_e[1], 1'b1);
    @(negedge clk);
    check_val("ws2_valid2", valid_m[1], 1'b0);
    check_val("ws2_stall2", stall_e[1], 1'b0);
    @(negedge clk);
    check_val("ws2_valid3", valid_m[1], 1'b1);
    check_val("ws2_data", read_data_m[1], 32'h0BADF00D);
    go_idle();

    // three wait states with flush in the second stall cycle
    mem_op(2, 1'b0, 1'b1, F3_W, 32'h40, 32'h5A5A5A5A);
    drive(2, 1'b0, 1'b0, 1'b1, F3_W, 32'h40, 32'hDEADBEEF, 5'd0);
    #1 check_val("fl_stall0", stall_e[2], 1'b1);
    @(negedge clk);
    flush_m = 1'b1;
    @(negedge clk);
    check_val("fl_valid", valid_m[2], 1'b0);
    go_idle();
    drive(2, 1'b1, 1'b1, 1'b0, F3_W, 32'h40, 32'd0, 5'd4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("fl_idle_bubble", valid_m[2], 1'b0);
    end
    @(negedge clk);
    check_val("fl_rd_valid", valid_m[2], 1'b1);
    check_val("fl_old_data", read_data_m[2], 32'h5A5A5A5A);

    // reset mid-WAIT abandons the store
    drive(2, 1'b0, 1'b0, 1'b1, F3_W, 32'h40, 32'h12345678, 5'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_val("rst_stall_comb", stall_e[2], 1'b0);
    @(negedge clk);
    check_val("rstw_valid", valid_m[2], 1'b0);
    check_val("rstw_regw", reg_write_m[2], 1'b0);
    check_val("rstw_alu", alu_result_m[2], 32'd0);
    check_val("rstw_rdata", read_data_m[2], 32'd0);
    check_val("rstw_pc", pc_plus4_m[2], 32'd0);
    check_val("rstw_fault", fault_m[2], 1'b0);
    go_idle();
    rst_n = 1'b1;
    @(negedge clk);
    mem_op(2, 1'b1, 1'b0, F3_W, 32'h40, 32'd0);
    check_val("rstw_nowrite", read_data_m[2], 32'h5A5A5A5A);
    go_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_pipe.md
MEM_STAGE_PIPE -- requirements
Module: mem_stage_pipe

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width; legal values 32 or 64.
REQ-003 SHALL have parameter DMEM_SIZE, default 64, data-memory depth in words; power of two.
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra memory-access cycles; legal range 0..3.
REQ-005 SHALL have ports clk  in  1  sole clock, rising edge; rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have execute-side inputs: valid_e 1, reg_write_e 1, result_src_e 2, mem_read_e 1, mem_write_e 1, funct3_e 3, alu_result_e DATA_WIDTH, write_data_e DATA_WIDTH, rd_e 5, pc_plus4_e ADDRESS_WIDTH.
REQ-007 SHALL have input flush_m 1, which kills the access in flight.
REQ-008 SHALL have output stall_e 1, telling the execute stage to hold its inputs.
REQ-009 SHALL have registered outputs: valid_m 1, reg_write_m 1, result_src_m 2, alu_result_m DATA_WIDTH, read_data_m DATA_WIDTH, rd_m 5, pc_plus4_m ADDRESS_WIDTH, fault_m 1.

Function
REQ-010 SHALL register all E inputs into M outputs: a non-memory op (valid_e=1, mem_read_e=mem_write_e=0) appears on the M outputs 1 cycle later, never stalls.
REQ-011 SHALL run an FSM with states IDLE and WAIT; reset state is IDLE.
REQ-012 SHALL, in IDLE with WAIT_STATES=0, complete a valid legal memory op at the next edge: write commits and load data registers into read_data_m.
REQ-013 SHALL, in IDLE with WAIT_STATES>0 and a valid legal memory op, drive stall_e=1, load counter with WAIT_STATES-1, and enter WAIT.
REQ-014 SHALL, in WAIT, drive stall_e=(counter!=0) and decrement each cycle; at counter=0 commit the access at that edge and return to IDLE.
REQ-015 SHALL make a memory op take exactly WAIT_STATES+1 cycles, with stall_e high for WAIT_STATES of them.
REQ-016 SHALL drive valid_m=0 and reg_write_m=0 (bubble) on every edge where stall_e was 1.
REQ-017 SHALL treat upstream inputs as stable while stall_e=1; a change is not required to be handled.
REQ-018 SHALL, on flush_m=1 in any state, return to IDLE, suppress the memory write, and register valid_m=0, reg_write_m=0 at that edge; flush outranks completion in the same cycle.
REQ-019 SHALL decode loads on funct3_e: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; for DATA_WIDTH=64 also 011 LD and 110 LWU; signed loads sign-extend and unsigned loads zero-extend to DATA_WIDTH.
REQ-020 SHALL decode stores on funct3_e: 000 SB, 001 SH, 010 SW; for DATA_WIDTH=64 also 011 SD; write only the addressed bytes via byte enables.
REQ-021 SHALL be little-endian; word index = alu_result_e bits above the byte offset, taken modulo DMEM_SIZE (upper bits ignored, address wraps).
REQ-022 SHALL flag a fault when the address is not aligned to the access size, or when funct3 is illegal for DATA_WIDTH: no stall, no write, valid_m=1, fault_m=1, reg_write_m=0, at 1-cycle latency.
REQ-023 SHALL give a simultaneous mem_read_e and mem_write_e the store behaviour; read_data_m is then don't-care.
REQ-024 SHALL ignore all inputs when valid_e=0, registering a bubble.

Reset
REQ-025 SHALL, on rst_n=0 at a rising edge, force state IDLE, counter 0, and every registered M output to 0; stall_e becomes 0 combinationally.
REQ-026 SHALL, on reset mid-WAIT, abandon the pending write, which never commits.
REQ-027 SHALL leave memory contents unreset.

Structure
REQ-028 SHALL place the funct3 load/store constants and the FSM state enum in a shared package, mem_pkg.
REQ-029 SHALL implement storage as one sub-module dmem_bank: a byte-enabled synchronous-write array with combinational read.

Verification
REQ-030 SHALL cover pass-through: add op with alu_result_e=0x1234, rd_e=5 -> next cycle valid_m=1, alu_result_m=0x1234, rd_m=5, stall_e never high.
REQ-031 SHALL cover byte access: SW 0x80FF7F01 at 0x10, then LB 0x11 -> 0x0000007F; LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LH 0x12 -> 0xFFFF80FF.
REQ-032 SHALL cover WAIT_STATES=2: LW -> stall_e high exactly 2 cycles, valid_m=0 on those 2 edges, data valid on the 3rd edge.
REQ-033 SHALL cover misalignment: LW at 0x22 -> fault_m=1, reg_write_m=0, no stall; SH at 0x21 -> memory unchanged on readback.
REQ-034 SHALL cover flush: WAIT_STATES=3 SW to 0x40, flush_m=1 in 2nd stall cycle -> state IDLE, valid_m=0, readback of 0x40 shows old value.
REQ-035 SHALL cover wrap and reset: DMEM_SIZE=64, SW to 0x100 aliases 0x000; rst_n=0 mid-WAIT -> all outputs 0, no write.
